power_ctrl: RTL and testbench
=============================

# power_ctrl

Power-state controller for the car. It turns the power button into a stable on/off state and drives the `start` enable consumed by the no-barrier power-off detector. It also accepts that detector's `power_off` request to shut the car down. This block is the other end of the `start` / `power_off` pair: it produces `start` and consumes `power_off`.

## Interface
Parameters:
- `LONG_PRESS_CYC`, default 100_000_000: consecutive synchronized-high cycles of the button needed to power on (1 s at 100 MHz). Must be >= 2.
- `OFF_PRESS_CYC`, default 50_000_000: consecutive synchronized-high cycles of the button needed to power off while on. Must be >= 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `power_btn`  in  1  raw power button, active high, asynchronous to `clk`.
- `power_off_req`  in  1  power-off request from the no-barrier detector, synchronous to `clk`, level.
- `start`  out  1  car powered; high in the ON_HOLD and ON states.
- `on_pulse`  out  1  one-cycle strobe on the off-to-on transition.
- `off_pulse`  out  1  one-cycle strobe on the on-to-off transition.
- `state`  out  3  current FSM state, for debug and LEDs.

## Operation
- `power_btn` passes through a 2-flop synchronizer (`btn_s`). `power_off_req` is used directly.
- A single counter `cnt` is used, with width `$clog2(max(LONG_PRESS_CYC, OFF_PRESS_CYC)+1)`. It is cleared on every state change and saturates; it never wraps.
- State encoding: OFF=0, ARM=1, ON_HOLD=2, ON=3, OFF_HOLD=4. Codes 5-7 go to OFF on the next edge.
- OFF:
  - `btn_s`=1 -> ARM, with `cnt`<=1.
  - `power_off_req` is ignored.
- ARM:
  - `btn_s`=0 -> OFF.
  - `btn_s`=1 and `cnt`==LONG_PRESS_CYC-1 -> ON_HOLD, and `on_pulse`=1.
  - Otherwise `cnt`+1.
  - `power_off_req` is ignored.
- ON_HOLD (powered, button still held from power-on):
  - `power_off_req`=1 -> OFF_HOLD, and `off_pulse`=1.
  - Else `btn_s`=0 -> ON.
  - Button time spent here never counts toward power-off.
- ON:
  - `power_off_req`=1 has priority. It goes to OFF_HOLD if `btn_s`=1, else to OFF. Either way `off_pulse`=1.
  - Else, `btn_s`=1 increments `cnt`. When `cnt` reaches OFF_PRESS_CYC, go to OFF_HOLD with `off_pulse`=1.
  - `btn_s`=0 clears `cnt`, so only consecutive presses count.
- OFF_HOLD (unpowered, waiting for release):
  - `btn_s`=0 -> OFF.
  - A held button never re-arms power-on.
- All outputs are registered.
  - `start`, `on_pulse` and `off_pulse` change on the same edge as `state`.
  - Each pulse is high for exactly 1 cycle.

## Timing
- Reset (async assert, removal sampled on `clk`): state=OFF, `cnt`=0, synchronizer=0, `start`=0, `on_pulse`=0, `off_pulse`=0.
- Asserting reset while ON drops `start` immediately and produces no `off_pulse`.
- Synchronizer latency is 2 edges. Number edges from the first edge that samples `power_btn`=1 as edge 1:
  - ARM is entered at edge 3.
  - `start` rises at edge LONG_PRESS_CYC+2.
- Power-off by button from ON: `start` falls at edge OFF_PRESS_CYC+2 of the press.
- Power-off by request: `start` falls on the first edge that samples `power_off_req`=1 in ON or ON_HOLD, a latency of 1 edge.
- A one-cycle `power_off_req` is sufficient. Requests in OFF, ARM or OFF_HOLD are dropped, not queued.
- A button release and `power_off_req` on the same edge in ON_HOLD resolve to OFF_HOLD. The following edge then goes to OFF.
- A press shorter than LONG_PRESS_CYC synchronized cycles returns to OFF with no output change.

## Test plan
All scenarios use LONG_PRESS_CYC=8 and OFF_PRESS_CYC=4.
- Reset: hold `rst_n`=0 with random inputs -> `start`=0, both pulses 0, `state`=0. Assert `rst_n`=0 mid-ON -> `start`=0 asynchronously, no `off_pulse`.
- Short press: `power_btn` high for 7 cycles -> `start` stays 0. `state` goes OFF->ARM->OFF.
- Long press of 20 cycles -> `start` rises at edge 10 with `on_pulse` high for 1 cycle. `state`=2 until `btn_s` falls, then 3. No power-off occurs despite 20 cycles held.
- In ON, a 1-cycle `power_off_req` -> `start` falls on that edge with `off_pulse` high for 1 cycle, `state`=0. A further `power_off_req` in OFF -> no effect.
- In ON:
  - A 3-cycle press, a release, then another 3-cycle press -> stays on, because `cnt` was cleared on release.
  - A 4-cycle press -> `start` falls at edge 6 of the press.
  - Holding the button 20 more cycles -> `state` stays 4, no re-arm. After release, an 8-cycle press powers on again.
- In ON_HOLD, `power_off_req`=1 together with the button held -> `state`=4, `off_pulse`=1. After release, `state` goes to 0.

Source files
------------

// File: rtl/power_ctrl.sv
// Power-state controller: debounces the power button into a stable on/off state,
// drives start, and honours power-off requests from the no-barrier detector.
module power_ctrl #(
  parameter int LONG_PRESS_CYC = 100_000_000,
  parameter int OFF_PRESS_CYC  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic       power_off_req,
  output logic       start,
  output logic       on_pulse,
  output logic       off_pulse,
  output logic [2:0] state
);

  // state    | meaning
  // OFF      | unpowered, idle
  // ARM      | unpowered, counting a power-on press
  // ON_HOLD  | powered, button still held from power-on
  // ON       | powered, counting consecutive power-off press cycles
  // OFF_HOLD | unpowered, waiting for button release
  typedef enum logic [2:0] {
    OFF      = 3'd0,
    ARM      = 3'd1,
    ON_HOLD  = 3'd2,
    ON       = 3'd3,
    OFF_HOLD = 3'd4
  } state_t;

  localparam int MAX_CYC = (LONG_PRESS_CYC > OFF_PRESS_CYC) ? LONG_PRESS_CYC : OFF_PRESS_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] ON_TC   = CW'(LONG_PRESS_CYC - 1);
  localparam logic [CW-1:0] OFF_TC  = CW'(OFF_PRESS_CYC - 1);

  state_t        st;
  logic          btn_m;
  logic          btn_s;
  logic [CW-1:0] cnt;

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= OFF;
      cnt       <= '0;
      btn_m     <= 1'b0;
      btn_s     <= 1'b0;
      start     <= 1'b0;
      on_pulse  <= 1'b0;
      off_pulse <= 1'b0;
    end else begin
      btn_m     <= power_btn;
      btn_s     <= btn_m;
      on_pulse  <= 1'b0;
      off_pulse <= 1'b0;
      case (st)
        OFF: begin
          if (btn_s) begin
            st  <= ARM;
            cnt <= CW'(1);
          end
        end
        ARM: begin
          if (!btn_s) begin
            st  <= OFF;
            cnt <= '0;
          end else if (cnt == ON_TC) begin
            st       <= ON_HOLD;
            cnt      <= '0;
            start    <= 1'b1;
            on_pulse <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        ON_HOLD: begin
          if (power_off_req) begin
            st        <= OFF_HOLD;
            cnt       <= '0;
            start     <= 1'b0;
            off_pulse <= 1'b1;
          end else if (!btn_s) begin
            st  <= ON;
            cnt <= '0;
          end
        end
        ON: begin
          if (power_off_req) begin
            st        <= btn_s ? OFF_HOLD : OFF;
            cnt       <= '0;
            start     <= 1'b0;
            off_pulse <= 1'b1;
          end else if (btn_s) begin
            // Leaving on the cycle cnt would reach OFF_PRESS_CYC.
            if (cnt == OFF_TC) begin
              st        <= OFF_HOLD;
              cnt       <= '0;
              start     <= 1'b0;
              off_pulse <= 1'b1;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        OFF_HOLD: begin
          if (!btn_s) begin
            st  <= OFF;
            cnt <= '0;
          end
        end
        default: begin
          st    <= OFF;
          cnt   <= '0;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_ctrl.sv
// Directed bench for power_ctrl with LONG_PRESS_CYC=8, OFF_PRESS_CYC=4.
module tb_power_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       power_btn;
  logic       power_off_req;
  logic       start;
  logic       on_pulse;
  logic       off_pulse;
  logic [2:0] state;

  int nvec = 0;
  int nerr = 0;

  power_ctrl #(.LONG_PRESS_CYC(8), .OFF_PRESS_CYC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .power_btn    (power_btn),
    .power_off_req(power_off_req),
    .start        (start),
    .on_pulse     (on_pulse),
    .off_pulse    (off_pulse),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press long enough to power on, then release and settle in ON.
  task automatic power_on();
    power_btn = 1'b1;
    repeat (10) tick();
    power_btn = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    power_btn     = 1'b0;
    power_off_req = 1'b0;

    for (int i = 0; i < 6; i++) begin
      power_btn     = 1'($urandom_range(0, 1));
      power_off_req = 1'($urandom_range(0, 1));
      tick();
      chk("rst_start", start, 3'd0);
    end
    chk("rst_on_pulse", on_pulse, 3'd0);
    chk("rst_off_pulse", off_pulse, 3'd0);
    chk("rst_state", state, 3'd0);
    power_btn     = 1'b0;
    power_off_req = 1'b0;
    rst_n         = 1'b1;
    repeat (3) tick();
    chk("idle_state", state, 3'd0);

    // Short press of 7 cycles
    power_btn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 2) chk("short_e2_state", state, 3'd0);
      if (i == 3) chk("short_e3_state", state, 3'd1);
      chk("short_start", start, 3'd0);
    end
    power_btn = 1'b0;
    for (int i = 8; i <= 12; i++) begin
      tick();
      chk("short_start", start, 3'd0);
      chk("short_on_pulse", on_pulse, 3'd0);
    end
    chk("short_end_state", state, 3'd0);

    // Long press of 20 cycles
    power_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 9) chk("long_e9_start", start, 3'd0);
      if (i == 10) begin
        chk("long_e10_start", start, 3'd1);
        chk("long_e10_on_pulse", on_pulse, 3'd1);
        chk("long_e10_state", state, 3'd2);
      end
      if (i == 11) chk("long_e11_on_pulse", on_pulse, 3'd0);
      if (i > 10) begin
        chk("long_hold_state", state, 3'd2);
        chk("long_hold_off_pulse", off_pulse, 3'd0);
      end
    end
    power_btn = 1'b0;
    repeat (2) tick();
    chk("long_rel2_state", state, 3'd2);
    tick();
    chk("long_rel3_state", state, 3'd3);
    chk("long_rel3_start", start, 3'd1);

    // One-cycle request in ON
    power_off_req = 1'b1;
    tick();
    power_off_req = 1'b0;
    chk("req_start", start, 3'd0);
    chk("req_off_pulse", off_pulse, 3'd1);
    chk("req_state", state, 3'd0);
    tick();
    chk("req_off_pulse_end", off_pulse, 3'd0);
    power_off_req = 1'b1;
    tick();
    power_off_req = 1'b0;
    chk("req_in_off_state", state, 3'd0);
    chk("req_in_off_pulse", off_pulse, 3'd0);
    tick();
    chk("req_in_off_start", start, 3'd0);

    // Two 3-cycle presses separated by a release stay on
    power_on();
    chk("on_again_state", state, 3'd3);
    power_btn = 1'b1;
    repeat (3) tick();
    power_btn = 1'b0;
    repeat (3) tick();
    power_btn = 1'b1;
    repeat (3) tick();
    power_btn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("split_press_off_pulse", off_pulse, 3'd0);
    end
    chk("split_press_start", start, 3'd1);
    chk("split_press_state", state, 3'd3);

    // 4-cycle press powers off at edge 6, then held 20 more cycles
    power_btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("offpress_e5_start", start, 3'd1);
      if (i == 6) begin
        chk("offpress_e6_start", start, 3'd0);
        chk("offpress_e6_off_pulse", off_pulse, 3'd1);
        chk("offpress_e6_state", state, 3'd4);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("offhold_state", state, 3'd4);
      chk("offhold_start", start, 3'd0);
    end
    chk("offhold_off_pulse", off_pulse, 3'd0);
    power_btn = 1'b0;
    repeat (3) tick();
    chk("offhold_rel_state", state, 3'd0);

    // 8-cycle press powers on again
    power_btn = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 9) power_btn = 1'b0;
      tick();
      if (i == 9) chk("repress_e9_start", start, 3'd0);
      if (i == 10) begin
        chk("repress_e10_start", start, 3'd1);
        chk("repress_e10_on_pulse", on_pulse, 3'd1);
      end
      if (i == 11) chk("repress_e11_state", state, 3'd3);
    end

    // Request together with held button in ON_HOLD
    power_off_req = 1'b1;
    tick();
    power_off_req = 1'b0;
    repeat (2) tick();
    power_btn = 1'b1;
    repeat (10) tick();
    chk("onhold_state", state, 3'd2);
    power_off_req = 1'b1;
    tick();
    power_off_req = 1'b0;
    chk("onhold_req_state", state, 3'd4);
    chk("onhold_req_off_pulse", off_pulse, 3'd1);
    chk("onhold_req_start", start, 3'd0);
    power_btn = 1'b0;
    repeat (3) tick();
    chk("onhold_rel_state", state, 3'd0);

    // Async reset while ON
    power_on();
    chk("pre_reset_start", start, 3'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_start", start, 3'd0);
    chk("async_rst_off_pulse", off_pulse, 3'd0);
    chk("async_rst_state", state, 3'd0);
    tick();
    chk("async_rst_off_pulse2", off_pulse, 3'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_reset_state", state, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
